// File: rtl/ysyx_22040575_pkg.sv
// ysyx_22040575_pkg: shared funct3 codes, LSU FSM encoding and default memory base
package ysyx_22040575_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [63:0] LSU_BASE_ADDR = 64'h8000_0000;
    typedef enum logic [1:0] {LSU_IDLE, LSU_WAIT, LSU_RESP} lsu_state_e;
endpackage

// File: rtl/ysyx_22040575_lsu_mem_if.sv
// ysyx_22040575_lsu_mem_if: request/response handshake bundle between EXU and data memory
interface ysyx_22040575_lsu_mem_if #(parameter int unsigned DATA_WIDTH = 64);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_22040575_lsu_align.sv
// ysyx_22040575_lsu_align: store byte-lane mask/shift and load extract/extend
module ysyx_22040575_lsu_align
    import ysyx_22040575_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [2:0]            funct3_i,
    input  logic [2:0]            lane_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] wbits_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [7:0]            bmask;
    logic [5:0]            bit_off;
    logic [DATA_WIDTH-1:0] sh;
    assign bit_off = {lane_i, 3'b000};
    assign bmask   = (funct3_i[1:0] == 2'd0 ? 8'h01 :
                      funct3_i[1:0] == 2'd1 ? 8'h03 :
                      funct3_i[1:0] == 2'd2 ? 8'h0F : 8'hFF) << lane_i;
    assign wdata_o = wdata_i << bit_off;
    for (genvar i = 0; i < 8; i++) begin : g_bits
        assign wbits_o[i*8 +: 8] = {8{bmask[i]}};
    end
    assign sh      = word_i >> bit_off;
    assign rdata_o = funct3_i == F3_B  ? {{(DATA_WIDTH-8){sh[7]}},   sh[7:0]}  :
                     funct3_i == F3_H  ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} :
                     funct3_i == F3_W  ? {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]} :
                     funct3_i == F3_D  ? sh :
                     funct3_i == F3_BU ? {{(DATA_WIDTH-8){1'b0}},    sh[7:0]}  :
                     funct3_i == F3_HU ? {{(DATA_WIDTH-16){1'b0}},   sh[15:0]} :
                     funct3_i == F3_WU ? {{(DATA_WIDTH-32){1'b0}},   sh[31:0]} : '0;
endmodule

// File: rtl/ysyx_22040575_lsu_mem.sv
// ysyx_22040575_lsu_mem: fixed-latency word SRAM responder for EXU load/store requests
// Define YSYX_22040575_MISALIGN_CHK_EN to flag misaligned accesses instead of silently aligning.
module ysyx_22040575_lsu_mem
    import ysyx_22040575_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 64,
    parameter int unsigned          MEM_DEPTH  = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR = LSU_BASE_ADDR,
    parameter int unsigned          LATENCY    = 2
) (
    input logic                    clk,
    input logic                    reset,
    ysyx_22040575_lsu_mem_if.slave bus
);
    localparam int unsigned IW     = $clog2(MEM_DEPTH);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    lsu_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  wen_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] off, word, wsh, wbits, ld;
    logic [IW-1:0]         idx;
    logic [2:0]            lane;
    logic [1:0]            sz;
    logic                  oor, illegal, bad, done, we;
    assign off     = addr_q - BASE_ADDR;
    assign idx     = off[IW+2:3];
    assign oor     = (addr_q < BASE_ADDR) || ((off >> 3) >= DATA_WIDTH'(MEM_DEPTH));
    assign illegal = wen_q ? f3_q[2] : (f3_q == 3'b111);
    assign sz      = f3_q[1:0];
`ifdef YSYX_22040575_MISALIGN_CHK_EN
    logic mis;
    assign mis  = sz == 2'd1 ? addr_q[0] : sz == 2'd2 ? |addr_q[1:0] : sz == 2'd3 ? |addr_q[2:0] : 1'b0;
    assign bad  = oor | illegal | mis;
    assign lane = addr_q[2:0];
`else
    logic [2:0] amask;
    assign amask = sz == 2'd1 ? 3'b110 : sz == 2'd2 ? 3'b100 : sz == 2'd3 ? 3'b000 : 3'b111;
    assign bad   = oor | illegal;
    assign lane  = addr_q[2:0] & amask;
`endif
    assign word = mem_q[idx];
    assign done = (state_q == LSU_WAIT) && (cnt_q == 4'd0);
    // a reset on the completion edge must also suppress the write
    assign we   = done & wen_q & ~bad & ~reset;
    ysyx_22040575_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3_i (f3_q),
        .lane_i   (lane),
        .wdata_i  (wdata_q),
        .word_i   (word),
        .wdata_o  (wsh),
        .wbits_o  (wbits),
        .rdata_o  (ld)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            LSU_IDLE: if (bus.req_valid) begin
                state_d = LSU_WAIT;
                cnt_d   = LAT_M1;
            end
            LSU_WAIT: if (cnt_q == 4'd0) begin
                state_d = LSU_RESP;
                rdata_d = (bad || wen_q) ? '0 : ld;
                err_d   = bad;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            LSU_RESP: if (bus.resp_ready) state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == LSU_IDLE && bus.req_valid) begin
            wen_q   <= bus.req_wen;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
        if (we) mem_q[idx] <= (word & ~wbits) | (wsh & wbits);
    end
    assign bus.req_ready  = state_q == LSU_IDLE;
    assign bus.resp_valid = state_q == LSU_RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
